// File: rtl/jtag_dmi_master.sv
// jtag_dmi_master
//   JTAG host that converts parallel DMI requests into bit-banged TCK/TMS/TDI
//   sequences. After reset (or tap_reset_i) it forces Test-Logic-Reset and
//   loads IR_DMI into the IR, then serves one DR scan per accepted request and
//   returns the raw DR value captured on TDO.
//
// Ports
//   clk, rst_n          system clock, asynchronous active-low reset
//   tap_reset_i         re-run the init sequence (honoured only in IDLE)
//   req_valid_i/ready_o request handshake; req_op_i/addr_i/data_i = DMI fields
//   resp_valid_o        one-cycle pulse; resp_data_o/resp_op_o = DR[33:2]/DR[1:0]
//   busy_o              high whenever not IDLE
//   jtag_tck_o/tms_o/tdi_o, jtag_tdo_i   JTAG pins
module jtag_dmi_master #(
  parameter int unsigned       TCK_DIV   = 5,
  parameter int unsigned       IR_LEN    = 5,
  parameter logic [IR_LEN-1:0] IR_DMI    = 5'b10001,
  parameter int unsigned       ABITS     = 6,
  parameter int unsigned       IDLE_BITS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tap_reset_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [1:0]       req_op_i,
  input  logic [ABITS-1:0] req_addr_i,
  input  logic [31:0]      req_data_i,
  output logic             resp_valid_o,
  output logic [31:0]      resp_data_o,
  output logic [1:0]       resp_op_o,
  output logic             busy_o,
  output logic             jtag_tck_o,
  output logic             jtag_tms_o,
  output logic             jtag_tdi_o,
  input  logic             jtag_tdo_i
);

  localparam int unsigned DR_LEN    = ABITS + 34;
  localparam int unsigned TRST_BITS = 8;
  localparam int unsigned IR_BITS   = IR_LEN + 7;
  localparam int unsigned DR_BITS   = DR_LEN + 5 + IDLE_BITS;
  localparam int unsigned BIT_W     = $clog2(TRST_BITS + IR_BITS + DR_BITS);
  localparam int unsigned CNT_W     = $clog2(2 * TCK_DIV) + 1;

  localparam logic [CNT_W-1:0] CNT_LOW_LAST   = CNT_W'(TCK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HIGH_FIRST = CNT_W'(TCK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST       = CNT_W'(2 * TCK_DIV - 1);

  typedef enum logic [2:0] {
    S_TRST,
    S_IR,
    S_IDLE,
    S_DR,
    S_DONE
  } state_e;

  // Index of the final TCK bit of each scanning state.
  function automatic logic [BIT_W-1:0] last_bit(input state_e st);
    logic [BIT_W-1:0] lb;
    case (st)
      S_TRST:  lb = BIT_W'(TRST_BITS - 1);
      S_IR:    lb = BIT_W'(IR_BITS - 1);
      S_DR:    lb = BIT_W'(DR_BITS - 1);
      default: lb = '0;
    endcase
    return lb;
  endfunction

  // {tms, tdi} for bit b of a scanning state. sr_lsb is the next DR bit to
  // shift out; TDI idles high outside shift bits.
  function automatic logic [1:0] bit_drive(input state_e st,
                                           input logic [BIT_W-1:0] b,
                                           input logic sr_lsb);
    int unsigned       bi;
    logic [IR_LEN-1:0] ir_sh;
    logic              tms;
    logic              tdi;
    bi    = 32'(b);
    ir_sh = IR_DMI;
    tms   = 1'b0;
    tdi   = 1'b1;
    case (st)
      S_TRST: tms = 1'b1;
      S_IR: begin
        if (bi < 5) begin
          // RTI, Select-DR, Select-IR, Capture-IR, Shift-IR
          tms = (bi == 1) || (bi == 2);
        end else if (bi < 5 + IR_LEN) begin
          tms   = (bi == 4 + IR_LEN);
          ir_sh = IR_DMI >> (bi - 5);
          tdi   = ir_sh[0];
        end else begin
          tms = (bi == 5 + IR_LEN);
        end
      end
      S_DR: begin
        if (bi < 3) begin
          tms = (bi == 0);
        end else if (bi < 3 + DR_LEN) begin
          tms = (bi == 2 + DR_LEN);
          tdi = sr_lsb;
        end else begin
          tms = (bi == 3 + DR_LEN);
        end
      end
      default: ;
    endcase
    return {tms, tdi};
  endfunction

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [DR_LEN-1:0]   sr_q, sr_d;
  logic                tck_q, tck_d;
  logic                tms_q, tms_d;
  logic                tdi_q, tdi_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                resp_valid_q, resp_valid_d;
  logic [31:0]         resp_data_q, resp_data_d;
  logic [1:0]          resp_op_q, resp_op_d;
  logic                new_bit;
  logic                dr_shift;

  // One shift register serves both directions: TDI takes sr[0] at the start
  // of a shift bit, TDO enters at the top just before the rising edge.
  assign dr_shift = (32'(bit_q) >= 3) && (32'(bit_q) < 3 + DR_LEN);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    sr_d         = sr_q;
    tms_d        = tms_q;
    tdi_d        = tdi_q;
    ready_d      = 1'b0;
    busy_d       = 1'b1;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    resp_op_d    = resp_op_q;
    new_bit      = 1'b0;

    case (state_q)
      S_TRST, S_IR, S_DR: begin
        if (state_q == S_DR && cnt_q == CNT_LOW_LAST && dr_shift) begin
          sr_d = {jtag_tdo_i, sr_q[DR_LEN-1:1]};
        end
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (bit_q == last_bit(state_q)) begin
            bit_d = '0;
            case (state_q)
              S_TRST: begin
                state_d = S_IR;
                new_bit = 1'b1;
              end
              S_IR: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
                busy_d  = 1'b0;
                tms_d   = 1'b0;
                tdi_d   = 1'b1;
              end
              default: begin
                state_d      = S_DONE;
                resp_valid_d = 1'b1;
                resp_data_d  = sr_q[33:2];
                resp_op_d    = sr_q[1:0];
                tms_d        = 1'b0;
                tdi_d        = 1'b1;
              end
            endcase
          end else begin
            bit_d   = bit_q + 1'b1;
            new_bit = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        // tap_reset takes priority; a coincident request stays pending.
        if (tap_reset_i) begin
          state_d = S_TRST;
          new_bit = 1'b1;
        end else if (req_valid_i && ready_q) begin
          state_d = S_DR;
          sr_d    = {req_addr_i, req_data_i, req_op_i};
          new_bit = 1'b1;
        end else begin
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    if (new_bit) begin
      {tms_d, tdi_d} = bit_drive(state_d, bit_d, sr_d[0]);
    end
    tck_d = (cnt_d >= CNT_HIGH_FIRST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_TRST;
      cnt_q        <= '0;
      bit_q        <= '0;
      sr_q         <= '0;
      tck_q        <= 1'b0;
      tms_q        <= 1'b1;
      tdi_q        <= 1'b1;
      ready_q      <= 1'b0;
      busy_q       <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_op_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      sr_q         <= sr_d;
      tck_q        <= tck_d;
      tms_q        <= tms_d;
      tdi_q        <= tdi_d;
      ready_q      <= ready_d;
      busy_q       <= busy_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_op_q    <= resp_op_d;
    end
  end

  assign req_ready_o  = ready_q;
  assign busy_o       = busy_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_data_o  = resp_data_q;
  assign resp_op_o    = resp_op_q;
  assign jtag_tck_o   = tck_q;
  assign jtag_tms_o   = tms_q;
  assign jtag_tdi_o   = tdi_q;

endmodule

// File: tb/tb_jtag_dmi_master.sv
// tb_jtag_dmi_master
//   Randomized bench for jtag_dmi_master at default parameters. A TDO driver
//   plays the target DR, TCK rises are logged as (TMS, TDI) pairs, and the
//   logs are compared against sequences built from the TAP walk rules.
module tb_jtag_dmi_master;

  localparam int         NTXN   = 14;
  localparam int         DRL    = 40;
  localparam logic [4:0] IR_EXP = 5'b10001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tap_reset_i = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [1:0]  req_op_i = '0;
  logic [5:0]  req_addr_i = '0;
  logic [31:0] req_data_i = '0;
  logic        resp_valid_o;
  logic [31:0] resp_data_o;
  logic [1:0]  resp_op_o;
  logic        busy_o;
  logic        jtag_tck_o;
  logic        jtag_tms_o;
  logic        jtag_tdi_o;
  logic        jtag_tdo_i = 1'b0;

  always #5 clk = ~clk;

  jtag_dmi_master dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tap_reset_i  (tap_reset_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_op_i     (req_op_i),
    .req_addr_i   (req_addr_i),
    .req_data_i   (req_data_i),
    .resp_valid_o (resp_valid_o),
    .resp_data_o  (resp_data_o),
    .resp_op_o    (resp_op_o),
    .busy_o       (busy_o),
    .jtag_tck_o   (jtag_tck_o),
    .jtag_tms_o   (jtag_tms_o),
    .jtag_tdi_o   (jtag_tdi_o),
    .jtag_tdo_i   (jtag_tdo_i)
  );

  int          n_tests = 0;
  int          n_fail = 0;
  int          resp_cnt = 0;
  bit          rise_tms[$];
  bit          rise_tdi[$];
  logic [39:0] tdo_word = '0;
  logic [31:0] last_resp = '0;

  logic [1:0]  t_op[NTXN];
  logic [5:0]  t_addr[NTXN];
  logic [31:0] t_data[NTXN];
  logic [39:0] t_tdo[NTXN];
  bit          t_keep[NTXN];

  // Target side: log every TCK rise, present the next DR bit on each fall.
  always @(posedge jtag_tck_o) begin
    rise_tms.push_back(jtag_tms_o);
    rise_tdi.push_back(jtag_tdi_o);
  end

  always @(negedge jtag_tck_o) begin
    int          r;
    logic [39:0] sh;
    r = rise_tms.size();
    if (r >= 3 && r < 3 + DRL) begin
      sh = tdo_word >> (r - 3);
      jtag_tdo_i = sh[0];
    end
  end

  always @(negedge clk) begin
    if (resp_valid_o === 1'b1) resp_cnt <= resp_cnt + 1;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (req_ready_o !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic clear_log();
    rise_tms.delete();
    rise_tdi.delete();
  endtask

  function automatic logic [63:0] tms_vec();
    logic [63:0] v = '0;
    for (int i = 0; i < rise_tms.size() && i < 64; i++) v[i] = rise_tms[i];
    return v;
  endfunction

  function automatic logic [63:0] tdi_vec();
    logic [63:0] v = '0;
    for (int i = 0; i < rise_tdi.size() && i < 64; i++) v[i] = rise_tdi[i];
    return v;
  endfunction

  // Caller is at the negedge where the init sequence starts.
  task automatic check_init(input string tag);
    int          n;
    logic [63:0] tms_e;
    logic [63:0] tdi_e;
    wait_ready(n);
    check({tag, "_ready_200clk"}, 64'(n >= 199 && n <= 201), 64'd1);
    check({tag, "_rises"}, 64'(rise_tms.size()), 64'd20);
    // 8 x TLR, then RTI, Sel-DR, Sel-IR, Cap-IR, Shift-IR, 5 shifts, Upd, RTI
    tms_e = '0;
    for (int i = 0; i < 8; i++) tms_e[i] = 1'b1;
    tms_e[9]  = 1'b1;
    tms_e[10] = 1'b1;
    tms_e[17] = 1'b1;
    tms_e[18] = 1'b1;
    check({tag, "_tms"}, tms_vec(), tms_e);
    tdi_e = '0;
    for (int i = 0; i < 20; i++) tdi_e[i] = (i >= 13 && i < 18) ? IR_EXP[i-13] : 1'b1;
    check({tag, "_tdi"}, tdi_vec(), tdi_e);
  endtask

  // One request; b2b means the previous one kept valid asserted.
  task automatic run_txn(input int i, input bit keep, input bit b2b);
    int          w;
    int          n;
    bit          rb_ok;
    logic [39:0] word;
    logic [63:0] tms_e;
    logic [63:0] sh_o;
    req_op_i    = t_op[i];
    req_addr_i  = t_addr[i];
    req_data_i  = t_data[i];
    req_valid_i = 1'b1;
    tdo_word    = t_tdo[i];
    word        = {t_addr[i], t_data[i], t_op[i]};
    check("resp_hold", 64'(resp_data_o), 64'(last_resp));
    wait_ready(w);
    if (b2b) check("b2b_wait", 64'(w), 64'd0);
    clear_log();
    @(negedge clk);
    if (keep && i + 1 < NTXN) begin
      req_op_i   = t_op[i+1];
      req_addr_i = t_addr[i+1];
      req_data_i = t_data[i+1];
    end else begin
      req_valid_i = 1'b0;
      req_data_i  = $urandom;
    end
    n = 1;
    rb_ok = 1'b1;
    while (resp_valid_o !== 1'b1 && n < 700) begin
      if (req_ready_o !== 1'b0 || busy_o !== 1'b1) rb_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    check("resp_latency_491", 64'(n >= 490 && n <= 492), 64'd1);
    check("scan_ready0_busy1", 64'(rb_ok), 64'd1);
    check("resp_data", 64'(resp_data_o), 64'(t_tdo[i][33:2]));
    check("resp_op", 64'(resp_op_o), 64'(t_tdo[i][1:0]));
    check("dr_rises", 64'(rise_tms.size()), 64'd49);
    // Sel-DR, Cap, Shift, 40 shifts (last exits), Upd, RTI, 4 idle
    tms_e = '0;
    tms_e[0]  = 1'b1;
    tms_e[42] = 1'b1;
    tms_e[43] = 1'b1;
    check("dr_tms", tms_vec(), tms_e);
    sh_o = tdi_vec() >> 3;
    check("dr_tdi_word", 64'(sh_o[39:0]), 64'(word));
    last_resp = t_tdo[i][33:2];
    @(negedge clk);
    check("single_pulse", 64'(resp_valid_o), 64'd0);
    if (keep && i + 1 < NTXN) check("b2b_ready", 64'(req_ready_o), 64'd1);
  endtask

  initial begin
    int          n;
    int          rc0;
    logic [39:0] abort_word;

    for (int i = 0; i < NTXN; i++) begin
      t_op[i]   = 2'($urandom_range(0, 3));
      t_addr[i] = 6'($urandom);
      t_data[i] = $urandom;
      t_tdo[i]  = {8'($urandom), 32'($urandom)};
      t_keep[i] = (i < NTXN - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    t_op[0]   = 2'd2;
    t_addr[0] = 6'h10;
    t_data[0] = 32'h0;
    t_keep[0] = 1'b0;
    t_tdo[1]  = {6'h2B, 32'hDEADBEEF, 2'b11};
    t_keep[2] = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_outputs",
          64'({jtag_tck_o, jtag_tms_o, jtag_tdi_o, req_ready_o, resp_valid_o, busy_o, resp_op_o, resp_data_o}),
          64'({1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 32'h0}));
    rst_n = 1'b1;
    clear_log();
    check_init("init");

    for (int i = 0; i < NTXN; i++) begin
      run_txn(i, t_keep[i], (i > 0) ? t_keep[i-1] : 1'b0);
    end

    // tap_reset coinciding with a request: reset wins, request not taken.
    rc0 = resp_cnt;
    tap_reset_i = 1'b1;
    req_valid_i = 1'b1;
    req_op_i    = 2'd1;
    req_addr_i  = 6'($urandom);
    @(negedge clk);
    tap_reset_i = 1'b0;
    req_valid_i = 1'b0;
    clear_log();
    check("trst_not_accepted", 64'({req_ready_o, busy_o}), 64'({1'b0, 1'b1}));
    check_init("tap_reset");
    check("trst_no_resp", 64'(resp_cnt), 64'(rc0));

    // Reset asserted in the middle of DR shift bit 20.
    abort_word  = {8'($urandom), 32'($urandom)};
    tdo_word    = abort_word;
    req_op_i    = 2'd1;
    req_addr_i  = 6'($urandom);
    req_data_i  = $urandom;
    req_valid_i = 1'b1;
    wait_ready(n);
    clear_log();
    @(negedge clk);
    req_valid_i = 1'b0;
    n = 0;
    while (rise_tms.size() < 23 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("abort_reach_bit20", 64'(rise_tms.size()), 64'd23);
    rc0 = resp_cnt;
    rst_n = 1'b0;
    #1;
    check("abort_rst_outputs",
          64'({jtag_tck_o, jtag_tms_o, jtag_tdi_o, req_ready_o, resp_valid_o, busy_o, resp_op_o, resp_data_o}),
          64'({1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 32'h0}));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    clear_log();
    last_resp = '0;
    check_init("abort_reinit");
    check("abort_no_resp", 64'(resp_cnt), 64'(rc0));

    run_txn(1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jtag_dmi_master.md
Name: jtag_dmi_master

Overview:
Synthesizable JTAG host that turns parallel DMI requests (op, addr, data) into bit-banged TCK/TMS/TDI sequences. It sits directly upstream of the SoC jtag_TCK/TMS/TDI/TDO pins and replaces hand-written TAP sequencing in benches and on-board bring-up. It returns the 40-bit DR value captured on TDO as a response.

Parameters:
TCK_DIV, 5, clk cycles per TCK half-period (minimum 1)
IR_DMI, 5'b10001, instruction loaded into IR at init
IR_LEN, 5, IR length in bits
ABITS, 6, DMI address width
IDLE_BITS, 4, extra Run-Test/Idle TCK cycles appended after each DR scan

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
tap_reset_i  input  1  pulse; re-run init sequence (honoured only in IDLE)
req_valid_i  input  1  DMI request valid
req_ready_o  output  1  request accepted when valid&ready
req_op_i  input  2  DMI op (0 nop, 1 read, 2 write, 3 passed unchanged)
req_addr_i  input  ABITS  DMI address
req_data_i  input  32  DMI write data
resp_valid_o  output  1  one-cycle pulse, response valid
resp_data_o  output  32  captured DR bits [33:2]
resp_op_o  output  2  captured DR bits [1:0]
busy_o  output  1  high whenever not in IDLE
jtag_tck_o  output  1  TCK
jtag_tms_o  output  1  TMS
jtag_tdi_o  output  1  TDI
jtag_tdo_i  input  1  TDO from target

Behaviour:
- One clock (clk); reset is asynchronous, active-low (rst_n). No other clock domains; TCK is a registered output.
- Reset values: tck=0, tms=1, tdi=1, req_ready=0, resp_valid=0, resp_data=0, resp_op=0, busy=1; FSM=TRST.
- Bit engine: each TCK bit = low phase of TCK_DIV clks, then high phase of TCK_DIV clks. TMS/TDI change only on the first clk of the low phase. TDO is sampled on the last clk of the low phase, i.e. before the rising edge.
- FSM states: TRST, IR, IDLE, DR, DONE.
- TRST: 8 bits, TMS=1. Then go to IR.
- IR: 12 bits. TMS sequence 0,1,1,0,0. Then IR_LEN shift bits carrying IR_DMI LSB first, with TMS=1 on the last bit. Then TMS=1 (Update-IR), then 0 (Idle). TDI=1 outside shift bits. Then go to IDLE.
- Init total is 20 bits, which is 200 clks at default parameters.
- IDLE: req_ready=1, busy=0, TCK held 0, TMS=0.
  - On req_valid&ready, latch shift word {addr,data,op} (40 bits at ABITS=6) and go to DR.
  - tap_reset_i in IDLE goes to TRST. If it coincides with req_valid, tap_reset wins and the request is not accepted.
- DR: TMS 1,0,0 (Select, Capture, Shift). Then 40 shift bits, LSB first, TMS=1 on the last bit. Then TMS 1 (Update), 0 (Idle). Then IDLE_BITS bits with TMS=0. Total 49 bits, which is 490 clks at default parameters.
  - TDO samples shift into bit 39 of the capture register, right-shifting each bit.
- DONE: one clk. resp_valid=1, resp_data=capture[33:2], resp_op=capture[1:0]. Next state is IDLE, so a new request can be accepted the clk after resp_valid.
- The response is the raw captured DR. The DTM returns the previous request's result, and pairing is the caller's responsibility.
- req_valid while not ready is ignored; the requester holds it.
- resp_data/resp_op hold their value until the next DONE.
- rst_n low mid-scan: immediate return to reset values. The aborted request produces no response. Full init reruns after release.

Test Plan:
- Reset release, TDO=0 → 8 TCK rises with TMS=1, then TDI on IR shift bits = 1,0,0,0,1. req_ready_o rises within 1 clk of the 20th TCK high phase ending (~200 clks).
- Write op=2, addr=0x10, data=0 → 40 shift-bit TDI stream equals {6'h10,32'h0,2'b10} LSB first. resp_valid pulses once, 491±1 clks after acceptance; no second pulse.
- TDO model shifts out {6'h2B,32'hDEADBEEF,2'b11} LSB first → resp_data_o=0xDEADBEEF, resp_op_o=3.
- req_valid held high for two requests → second accepted exactly 1 clk after the first resp_valid. req_ready stays 0 and busy stays 1 throughout each scan.
- rst_n pulsed low during DR shift bit 20 → outputs immediately at reset values. No resp_valid for the aborted request. After release, 20-bit init reruns and ready rises again.
- tap_reset_i pulse in IDLE, together with req_valid → request not accepted, 8 TMS=1 bits followed by the IR sequence, ready low for ~200 clks.
